// File: rtl/mdu_iter_if.sv
// Handshake and operand/result bundle between the EX stage and the iterative
// multiply/divide unit. The EX stage drives the master side; mdu_iter is the slave.
interface mdu_iter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             dbz;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, hi, lo, dbz
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, hi, lo, dbz
   );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the EX stage.
// op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Works on operand magnitudes and
// applies sign correction in FIX; results land on hi/lo/dbz only in FIX.
// Optional macro MDU_FAST_MUL_EN: multiplies bypass RUN (IDLE -> FIX in one cycle).
//
// state | meaning
// IDLE  | waiting for start, counter held at 0
// RUN   | one shift-add (mul) or restoring shift-subtract (div) step per cycle
// FIX   | sign correction, load hi/lo/dbz, pulse done
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   mdu_iter_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             isDiv;
   logic             aNeg;
   logic             bNeg;
   logic             bZero;
   logic [WIDTH-1:0] magA;
   logic [WIDTH-1:0] magB;
   logic [WIDTH-1:0] hiAcc;
   logic [WIDTH-1:0] loAcc;

   logic             aNegIn;
   logic             bNegIn;
   logic [WIDTH-1:0] magAIn;
   logic [WIDTH-1:0] magBIn;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   divShift;
   logic             divGe;
   logic [WIDTH-1:0] divRem;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0] quoFix;
   logic [WIDTH-1:0] remFix;
`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0] fastProd;
`endif

   // Operand magnitudes, one datapath step, and the FIX-stage sign correction.
   always_comb begin
      aNegIn   = bus.op[0] & bus.a[WIDTH-1];
      bNegIn   = bus.op[0] & bus.b[WIDTH-1];
      magAIn   = aNegIn ? -bus.a : bus.a;
      magBIn   = bNegIn ? -bus.b : bus.b;

      mulSum   = {1'b0, hiAcc} + (loAcc[0] ? {1'b0, magA} : '0);

      // Partial remainder stays below magB, so the compare fits in WIDTH+1 bits.
      divShift = {hiAcc, loAcc[WIDTH-1]};
      divGe    = divShift >= {1'b0, magB};
      divRem   = divGe ? WIDTH'(divShift - {1'b0, magB}) : divShift[WIDTH-1:0];

      prodFix  = (aNeg ^ bNeg) ? -{hiAcc, loAcc} : {hiAcc, loAcc};
      // Divide by zero: quotient is all ones; the remainder already equals a
      // once the dividend's sign is put back.
      quoFix   = bZero ? '1 : ((aNeg ^ bNeg) ? -loAcc : loAcc);
      remFix   = aNeg ? -hiAcc : hiAcc;
`ifdef MDU_FAST_MUL_EN
      fastProd = {{WIDTH{1'b0}}, magAIn} * {{WIDTH{1'b0}}, magBIn};
`endif
   end

   // Control FSM, iteration datapath and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         isDiv    <= 1'b0;
         aNeg     <= 1'b0;
         bNeg     <= 1'b0;
         bZero    <= 1'b0;
         magA     <= '0;
         magB     <= '0;
         hiAcc    <= '0;
         loAcc    <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.hi   <= '0;
         bus.lo   <= '0;
         bus.dbz  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (bus.flush) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (bus.start) begin
                     isDiv    <= bus.op[1];
                     aNeg     <= aNegIn;
                     bNeg     <= bNegIn;
                     bZero    <= (bus.b == '0);
                     magA     <= magAIn;
                     magB     <= magBIn;
                     hiAcc    <= '0;
                     loAcc    <= bus.op[1] ? magAIn : magBIn;
                     state    <= RUN;
                     bus.busy <= 1'b1;
`ifdef MDU_FAST_MUL_EN
                     if (!bus.op[1]) begin
                        hiAcc <= fastProd[2*WIDTH-1:WIDTH];
                        loAcc <= fastProd[WIDTH-1:0];
                        state <= FIX;
                     end
`endif
                  end
               end
               RUN: begin
                  cnt <= cnt + CW'(1);
                  if (isDiv) begin
                     hiAcc <= divRem;
                     loAcc <= {loAcc[WIDTH-2:0], divGe};
                  end else begin
                     hiAcc <= mulSum[WIDTH:1];
                     loAcc <= {mulSum[0], loAcc[WIDTH-1:1]};
                  end
                  if (cnt == CW'(WIDTH - 1)) begin
                     state <= FIX;
                  end
               end
               FIX: begin
                  if (isDiv) begin
                     bus.hi  <= remFix;
                     bus.lo  <= quoFix;
                     bus.dbz <= bZero;
                  end else begin
                     bus.hi  <= prodFix[2*WIDTH-1:WIDTH];
                     bus.lo  <= prodFix[WIDTH-1:0];
                     bus.dbz <= 1'b0;
                  end
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  cnt      <= '0;
                  state    <= IDLE;
               end
               default: begin
                  state    <= IDLE;
                  cnt      <= '0;
                  bus.busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed products, quotients, handshake,
// flush and reset cases. Honours MDU_FAST_MUL_EN for multiply latency.
module tb_mdu_iter;

   localparam int WIDTH = 32;
   localparam int DIV_LAT = WIDTH + 1;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = WIDTH + 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   nChecks = 0;
   int   nErrs = 0;

   mdu_iter_if #(.WIDTH(WIDTH)) bus ();

   mdu_iter #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic waitDone(output int cyc);
      cyc = 0;
      while (!bus.done && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic countDones(input int n, output int d);
      d = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.done) d++;
      end
   endtask

   task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] expHi,
                        input logic [31:0] expLo, input logic expDbz);
      int cyc;
      startOp(op, a, b);
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      waitDone(cyc);
      check({tag, "_lat"}, 64'(cyc), 64'(lat));
      check({tag, "_hi"}, 64'(bus.hi), 64'(expHi));
      check({tag, "_lo"}, 64'(bus.lo), 64'(expLo));
      check({tag, "_dbz"}, 64'(bus.dbz), 64'(expDbz));
      check({tag, "_busyDone"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int cyc;
      int d;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      bus.flush = 1'b0;

      tick();
      tick();
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      check("rst_dbz", 64'(bus.dbz), 64'd0);
      rst = 1'b1;
      tick();

      runOp("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      runOp("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      runOp("mult_nn", 2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, MUL_LAT, 32'h0, 32'h1E, 1'b0);
      runOp("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      runOp("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'd1, 32'hFFFF_FFFD, 1'b0);
      runOp("div_min", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000, 1'b0);
      runOp("divu_100_7", 2'b10, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 1'b0);
      runOp("divu_z", 2'b10, 32'h1234_5678, 32'h0, DIV_LAT, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
      runOp("multu_2_3", 2'b00, 32'd2, 32'd3, MUL_LAT, 32'h0, 32'd6, 1'b0);
      runOp("div_z", 2'b11, 32'hFFFF_FFFB, 32'h0, DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

      // start while busy is ignored
      startOp(2'b10, 32'd100, 32'd7);
      repeat (4) tick();
      startOp(2'b10, 32'd9, 32'd3);
      waitDone(cyc);
      check("ign_lat", 64'(cyc + 5), 64'(DIV_LAT));
      check("ign_lo", 64'(bus.lo), 64'd14);
      check("ign_hi", 64'(bus.hi), 64'd2);
      countDones(40, d);
      check("ign_ndone", 64'(d), 64'd0);

      // start in the done cycle is accepted
      startOp(2'b10, 32'd50, 32'd5);
      waitDone(cyc);
      check("b2b1_lat", 64'(cyc), 64'(DIV_LAT));
      check("b2b1_lo", 64'(bus.lo), 64'd10);
      startOp(2'b10, 32'd20, 32'd6);
      waitDone(cyc);
      check("b2b2_lat", 64'(cyc), 64'(DIV_LAT));
      check("b2b2_lo", 64'(bus.lo), 64'd3);
      check("b2b2_hi", 64'(bus.hi), 64'd2);

      // flush mid-divide
      startOp(2'b10, 32'd1000, 32'd3);
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush_busy", 64'(bus.busy), 64'd0);
      countDones(40, d);
      check("flush_ndone", 64'(d), 64'd0);
      check("flush_hi", 64'(bus.hi), 64'd2);
      check("flush_lo", 64'(bus.lo), 64'd3);

      // start together with flush is not accepted
      bus.flush = 1'b1;
      startOp(2'b10, 32'd1000, 32'd3);
      bus.flush = 1'b0;
      check("sf_busy", 64'(bus.busy), 64'd0);
      countDones(40, d);
      check("sf_ndone", 64'(d), 64'd0);

      // async reset mid-run clears outputs without a clock edge
      startOp(2'b10, 32'd1000, 32'd3);
      repeat (5) tick();
      rst = 1'b0;
      #2;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_done", 64'(bus.done), 64'd0);
      check("arst_hi", 64'(bus.hi), 64'd0);
      check("arst_lo", 64'(bus.lo), 64'd0);
      check("arst_dbz", 64'(bus.dbz), 64'd0);
      tick();
      rst = 1'b1;
      tick();
      runOp("post_rst", 2'b10, 32'd1000, 32'd3, DIV_LAT, 32'd1, 32'd333, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nErrs);
      $finish;
   end

endmodule
